pet_io_hub: RTL and testbench

//  Parametrised successor to the fixed PET I/O decoder. It one-hot decodes a CPU access inside the
//  I/O page onto NUM_DEV peripheral slots (PIA, VIA, CRTC, ...) and issues one-clk device strobes.
//  It applies programmable wait states, registers the AND-combined read data and aggregates masked

---
 rtl/pet_io_hub.sv | 166 ++++++++++++++++
 tb/tb_pet_io_hub.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pet_io_hub.sv
// pet_io_hub: I/O page decoder for the PET peripheral slots.
// One-hot decodes a CPU access onto NUM_DEV slots, issues a one-clk strobe,
// applies wait states, registers the AND-combined read data and aggregates
// masked device IRQs. Hub IRQ status/mask registers answer when no slot is hit.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for ce&cs; releases rdy one edge after a capture
// S_STROBE  | slot strobe and dev_we high for one clk; hub register write
// S_WAIT    | wait states, wcnt runs 0..WAIT_CYCLES-1
// S_CAPTURE | read data registered into data_out (reads only)
module pet_io_hub #(
  parameter int          NUM_DEV     = 4,
  parameter int          ADDR_W      = 8,
  parameter int          SEL_LSB     = 4,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [7:0]  OPEN_BUS    = 8'hE8,
  parameter bit          HUB_REGS_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 rdy,
  input  logic [NUM_DEV-1:0]   dev_present,
  output logic [NUM_DEV-1:0]   dev_strobe,
  output logic                 dev_we,
  input  logic [8*NUM_DEV-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]   dev_irq,
  output logic                 irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STROBE  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [3:0] WCNT_LAST = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t             state;
  logic [3:0]         wcnt;
  logic               rdy_pend;
  logic [NUM_DEV-1:0] sel_raw;
  logic [NUM_DEV-1:0] sel_l;
  logic               we_l;
  logic               addr0_l;
  logic [NUM_DEV-1:0] wdata_l;
  logic [NUM_DEV-1:0] mask;
  logic [7:0]         rd_and;
  logic [7:0]         hub_status;
  logic [7:0]         hub_mask;
  logic [7:0]         rd_next;
  logic               unused_bits;

  // Only addr[0], the slot select bits and the low data bits are consumed
  assign unused_bits = ^{addr, data_in};

  // Slot decode: a slot is hit only if its address bit is set and it is populated
  always_comb begin
    sel_raw = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      sel_raw[i] = cs & addr[SEL_LSB+i] & dev_present[i];
    end
  end

  // Read data source: AND of selected slots, else hub registers or open bus
  always_comb begin
    rd_and     = 8'hFF;
    hub_status = 8'h00;
    hub_mask   = 8'h00;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (sel_l[i]) begin
        rd_and = rd_and & dev_rdata[8*i +: 8];
      end
      hub_status[i] = dev_irq[i] & mask[i];
      hub_mask[i]   = mask[i];
    end
    if (sel_l != '0) begin
      rd_next = rd_and;
    end else if (!HUB_REGS_EN) begin
      rd_next = OPEN_BUS;
    end else if (addr0_l) begin
      rd_next = hub_mask;
    end else begin
      rd_next = hub_status;
    end
  end

  // Access sequencer with registered strobe/rdy/data outputs and the hub mask register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wcnt       <= 4'd0;
      rdy        <= 1'b1;
      rdy_pend   <= 1'b0;
      dev_strobe <= '0;
      dev_we     <= 1'b0;
      data_out   <= OPEN_BUS;
      mask       <= '1;
      sel_l      <= '0;
      we_l       <= 1'b0;
      addr0_l    <= 1'b0;
      wdata_l    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rdy_pend) begin
            rdy      <= 1'b1;
            rdy_pend <= 1'b0;
          end
          if (ce && cs) begin
            sel_l      <= sel_raw;
            we_l       <= we;
            addr0_l    <= addr[0];
            wdata_l    <= data_in[NUM_DEV-1:0];
            dev_strobe <= sel_raw;
            dev_we     <= we;
            state      <= S_STROBE;
          end
        end
        S_STROBE: begin
          dev_strobe <= '0;
          dev_we     <= 1'b0;
          rdy        <= 1'b0;
          wcnt       <= 4'd0;
          if (HUB_REGS_EN && we_l && (sel_l == '0) && addr0_l) begin
            mask <= wdata_l;
          end
          state <= (WAIT_CYCLES > 0) ? S_WAIT : S_CAPTURE;
        end
        S_WAIT: begin
          if (wcnt == WCNT_LAST) begin
            wcnt  <= 4'd0;
            state <= S_CAPTURE;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        S_CAPTURE: begin
          if (!we_l) begin
            data_out <= rd_next;
          end
          rdy_pend <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Masked IRQ aggregation, free-running with one clk latency
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(dev_irq & mask);
    end
  end

endmodule

// File: tb/tb_pet_io_hub.sv
// tb_pet_io_hub: scoreboard bench for pet_io_hub.
// dut_a: WAIT_CYCLES=0 with hub registers; dut_b: WAIT_CYCLES=3 without hub registers.
// Both share all inputs; expected read data is queued when an access is issued.
module tb_pet_io_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce, cs, we;
  logic [7:0]  addr, data_in;
  logic [3:0]  dev_present;
  logic [31:0] dev_rdata;
  logic [3:0]  dev_irq;

  logic [7:0]  data_out_a, data_out_b;
  logic        rdy_a, rdy_b;
  logic [3:0]  strobe_a, strobe_b;
  logic        we_a, we_b;
  logic        irq_a, irq_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  pet_io_hub #(.NUM_DEV(4), .ADDR_W(8), .SEL_LSB(4), .WAIT_CYCLES(0),
               .OPEN_BUS(8'hE8), .HUB_REGS_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .cs(cs), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out_a), .rdy(rdy_a),
    .dev_present(dev_present), .dev_strobe(strobe_a), .dev_we(we_a),
    .dev_rdata(dev_rdata), .dev_irq(dev_irq), .irq(irq_a)
  );

  pet_io_hub #(.NUM_DEV(4), .ADDR_W(8), .SEL_LSB(4), .WAIT_CYCLES(3),
               .OPEN_BUS(8'hE8), .HUB_REGS_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .cs(cs), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out_b), .rdy(rdy_b),
    .dev_present(dev_present), .dev_strobe(strobe_b), .dev_we(we_b),
    .dev_rdata(dev_rdata), .dev_irq(dev_irq), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One CPU access: check strobe window, rdy latency of both DUTs, then scoreboard data
  task automatic access(input string tag, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic [3:0] exp_stb,
                        input logic [7:0] exp_a, input logic [7:0] exp_b);
    int lat_a, lat_b, extra;
    logic [7:0] ea, eb;
    qa.push_back(exp_a);
    qb.push_back(exp_b);
    @(posedge clk); #1;
    ce = 1'b1; cs = 1'b1; we = w; addr = a; data_in = d;
    @(posedge clk); #1;
    ce = 1'b0; cs = 1'b0; we = 1'b0;
    chk({tag, "_stb_a"}, 32'(strobe_a), 32'(exp_stb));
    chk({tag, "_stb_b"}, 32'(strobe_b), 32'(exp_stb));
    chk({tag, "_we_a"},  32'(we_a), 32'(w));
    chk({tag, "_we_b"},  32'(we_b), 32'(w));
    lat_a = 0; lat_b = 0; extra = 0;
    for (int e = 1; e <= 30 && (lat_a == 0 || lat_b == 0); e++) begin
      @(posedge clk); #1;
      if (strobe_a != 4'd0 || strobe_b != 4'd0) extra++;
      if (lat_a == 0 && rdy_a) lat_a = e;
      if (lat_b == 0 && rdy_b) lat_b = e;
    end
    chk({tag, "_lat_a"}, 32'(lat_a), 32'd3);
    chk({tag, "_lat_b"}, 32'(lat_b), 32'd6);
    chk({tag, "_extra_stb"}, 32'(extra), 32'd0);
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk({tag, "_data_a"}, 32'(data_out_a), 32'(ea));
    chk({tag, "_data_b"}, 32'(data_out_b), 32'(eb));
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; cs = 1'b0; we = 1'b0; addr = 8'h00; data_in = 8'h00;
    dev_present = 4'b0111;
    dev_rdata   = {8'h11, 8'h77, 8'h3C, 8'h5A};
    dev_irq     = 4'b0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_data_a", 32'(data_out_a), 32'hE8);
    chk("rst_data_b", 32'(data_out_b), 32'hE8);
    chk("rst_rdy_a", 32'(rdy_a), 32'd1);
    chk("rst_rdy_b", 32'(rdy_b), 32'd1);
    chk("rst_stb_a", 32'(strobe_a), 32'd0);
    chk("rst_we_a", 32'(we_a), 32'd0);
    chk("rst_irq_a", 32'(irq_a), 32'd0);

    // reset mask is all ones
    access("mask_rst", 1'b0, 8'h01, 8'h00, 4'b0000, 8'h0F, 8'hE8);

    // single slot read and slot write
    access("rd_slot0", 1'b0, 8'h10, 8'h00, 4'b0001, 8'h5A, 8'h5A);
    access("wr_slot2", 1'b1, 8'h40, 8'hC3, 4'b0100, 8'h5A, 8'h5A);

    // multi-select ANDs the slots; absent slot3 drops out of the AND
    dev_rdata[7:0] = 8'hF0;
    access("rd_multi", 1'b0, 8'h30, 8'h00, 4'b0011, 8'h30, 8'h30);
    access("rd_multi_abs", 1'b0, 8'hB0, 8'h00, 4'b0011, 8'h30, 8'h30);

    // only absent slot hit: hub status on dut_a, open bus on dut_b
    dev_irq = 4'b0101;
    access("rd_absent", 1'b0, 8'h80, 8'h00, 4'b0000, 8'h05, 8'hE8);

    // mask write and IRQ aggregation
    access("wr_mask", 1'b1, 8'h01, 8'h02, 4'b0000, 8'h05, 8'hE8);
    dev_irq = 4'b0011;
    @(posedge clk); #1;
    chk("irq_on_a", 32'(irq_a), 32'd1);
    chk("irq_on_b", 32'(irq_b), 32'd1);
    dev_irq = 4'b0001;
    @(posedge clk); #1;
    chk("irq_off_a", 32'(irq_a), 32'd0);
    chk("irq_off_b", 32'(irq_b), 32'd1);
    access("rd_status", 1'b0, 8'h00, 8'h00, 4'b0000, 8'h00, 8'hE8);
    access("rd_mask", 1'b0, 8'h01, 8'h00, 4'b0000, 8'h02, 8'hE8);

    // ce without cs stays idle
    @(posedge clk); #1;
    ce = 1'b1; cs = 1'b0; addr = 8'h10;
    @(posedge clk); #1;
    ce = 1'b0;
    chk("nocs_stb", 32'(strobe_a | strobe_b), 32'd0);
    @(posedge clk); #1;
    chk("nocs_rdy_a", 32'(rdy_a), 32'd1);
    chk("nocs_rdy_b", 32'(rdy_b), 32'd1);

    // reset during dut_b WAIT with a busy-time access in between
    @(posedge clk); #1;
    ce = 1'b1; cs = 1'b1; we = 1'b0; addr = 8'h20;
    @(posedge clk); #1;
    ce = 1'b0; cs = 1'b0;
    chk("mid_stb_b", 32'(strobe_b), 32'b0010);
    @(posedge clk); #1;
    ce = 1'b1; cs = 1'b1; addr = 8'h10;
    @(posedge clk); #1;
    ce = 1'b0; cs = 1'b0;
    reset = 1'b1;
    chk("busy_stb", 32'(strobe_a | strobe_b), 32'd0);
    chk("busy_rdy_b", 32'(rdy_b), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_stb_b", 32'(strobe_b), 32'd0);
    chk("mrst_rdy_b", 32'(rdy_b), 32'd1);
    chk("mrst_rdy_a", 32'(rdy_a), 32'd1);
    chk("mrst_data_b", 32'(data_out_b), 32'hE8);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("mrst_quiet", 32'(strobe_a | strobe_b), 32'd0);
    end
    access("mrst_mask", 1'b0, 8'h01, 8'h00, 4'b0000, 8'h0F, 8'hE8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
